// File: rtl/chip8_mem_arbiter.sv
// CHIP-8 main RAM owner: round-robin arbiter over NUM_PORTS requestors plus a flash sequencer
// that copies a library program to PROG_BASE. Define CHIP8_FONT_PRELOAD_EN to preload the hex font.
module chip8_mem_arbiter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned LIB_LATENCY = 2,
  parameter int unsigned PROG_BASE   = 'h200
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        flash_in,
  input  logic [ADDR_W-1:0]           prog_len_in,
  output logic [ADDR_W-1:0]           lib_addr_out,
  input  logic [DATA_W-1:0]           lib_data_in,
  output logic                        busy_out,
  input  logic [NUM_PORTS-1:0]        req_in,
  input  logic [NUM_PORTS-1:0]        we_in,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_in,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  output logic [NUM_PORTS-1:0]        gnt_out,
  output logic [NUM_PORTS-1:0]        rvalid_out,
  output logic [DATA_W-1:0]           rdata_out
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {StServe, StLoad, StDrain, StFont} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [PW-1:0]     prio_q, prio_d;

  logic [LIB_LATENCY-1:0] lib_vld_q;
  logic [ADDR_W-1:0]      lib_dst_q [LIB_LATENCY];
  logic                   lib_issue, lib_pend;

  logic [DATA_W-1:0]    mem [2**ADDR_W];
  logic [DATA_W-1:0]    rd_data_q [RAM_LATENCY];
  logic [NUM_PORTS-1:0] rd_vld_q  [RAM_LATENCY];

  logic [PW-1:0]        cand, win;
  logic                 found, serve_en;
  logic [NUM_PORTS-1:0] gnt;
  logic                 acc_we;
  logic [ADDR_W-1:0]    acc_addr;
  logic [DATA_W-1:0]    acc_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

`ifdef CHIP8_FONT_PRELOAD_EN
  localparam logic [639:0] FontRom = 640'hF0909090F0_2060202070_F010F080F0_F010F010F0_9090F01010_F080F010F0_F080F090F0_F010204040_F090F090F0_F090F010F0_F090F09090_E090E090E0_F0808080F0_E0909090E0_F080F080F0_F080F08080;
  logic [6:0] font_q, font_d;
  logic [7:0] font_byte;
  assign font_byte = FontRom[10'(32'd639 - 32'd8 * 32'(font_q)) -: 8];
`endif

  // Round-robin search starting at prio_q; first requesting port wins.
  always_comb begin
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((32'(prio_q) + i) % NUM_PORTS);
      if (!found && req_in[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign serve_en = rst_in && (state_q == StServe) && !flash_in;
  assign gnt      = (serve_en && found) ? (NUM_PORTS'(1) << win) : '0;
  assign prio_d   = (serve_en && found) ? PW'((32'(win) + 32'd1) % NUM_PORTS) : prio_q;
  assign acc_we   = we_in[win];
  assign acc_addr = addr_in[32'(win) * ADDR_W +: ADDR_W];
  assign acc_data = data_in[32'(win) * DATA_W +: DATA_W];

  // Writes still due after the one landing this cycle.
  always_comb begin
    lib_pend = 1'b0;
    for (int i = 0; i < int'(LIB_LATENCY) - 1; i++) begin
      lib_pend = lib_pend | lib_vld_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    lib_issue = 1'b0;
`ifdef CHIP8_FONT_PRELOAD_EN
    font_d    = font_q;
`endif
    case (state_q)
      StServe: begin
        if (flash_in) begin
          len_d   = prog_len_in;
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (len_q == '0) begin
          state_d = StServe;
        end else begin
          lib_issue = 1'b1;
          idx_d     = idx_q + ADDR_W'(1);
          if (idx_q == len_q - ADDR_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!lib_pend) state_d = StServe;
      end
      StFont: begin
`ifdef CHIP8_FONT_PRELOAD_EN
        font_d = font_q + 7'd1;
        if (font_q == 7'd79) state_d = StServe;
`else
        state_d = StServe;
`endif
      end
      default: state_d = StServe;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
`ifdef CHIP8_FONT_PRELOAD_EN
      state_q <= StFont;
      font_q  <= '0;
`else
      state_q <= StServe;
`endif
      len_q     <= '0;
      idx_q     <= '0;
      prio_q    <= '0;
      lib_vld_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      prio_q       <= prio_d;
      lib_vld_q[0] <= lib_issue;
      for (int i = 1; i < int'(LIB_LATENCY); i++) lib_vld_q[i] <= lib_vld_q[i-1];
`ifdef CHIP8_FONT_PRELOAD_EN
      font_q <= font_d;
`endif
    end
  end

  // Destination travels alongside the library read; wraps modulo RAM depth.
  always_ff @(posedge clk_in) begin
    lib_dst_q[0] <= ADDR_W'(PROG_BASE) + idx_q;
    for (int i = 1; i < int'(LIB_LATENCY); i++) lib_dst_q[i] <= lib_dst_q[i-1];
  end

  // Writes are suppressed while reset is asserted so an aborted copy stops cleanly.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = acc_addr;
    wr_data = acc_data;
    if (lib_vld_q[LIB_LATENCY-1]) begin
      wr_en   = rst_in;
      wr_addr = lib_dst_q[LIB_LATENCY-1];
      wr_data = lib_data_in;
    end
`ifdef CHIP8_FONT_PRELOAD_EN
    else if (state_q == StFont) begin
      wr_en   = rst_in;
      wr_addr = ADDR_W'(32'h50 + 32'(font_q));
      wr_data = DATA_W'(font_byte);
    end
`endif
    else if ((|gnt) && acc_we) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(RAM_LATENCY); i++) begin
        rd_data_q[i] <= '0;
        rd_vld_q[i]  <= '0;
      end
    end else begin
      rd_data_q[0] <= mem[acc_addr];
      rd_vld_q[0]  <= gnt & ~{NUM_PORTS{acc_we}};
      for (int i = 1; i < int'(RAM_LATENCY); i++) begin
        rd_data_q[i] <= rd_data_q[i-1];
        rd_vld_q[i]  <= rd_vld_q[i-1];
      end
    end
  end

  assign gnt_out      = gnt;
  assign rvalid_out   = rd_vld_q[RAM_LATENCY-1];
  assign rdata_out    = rd_data_q[RAM_LATENCY-1];
  assign busy_out     = (state_q != StServe);
  assign lib_addr_out = (state_q == StLoad) ? idx_q : '0;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Randomised scoreboard bench for chip8_mem_arbiter (default build, font preload disabled).
module tb_chip8_mem_arbiter;

  localparam int NP = 2;
  localparam int RAM_LAT = 2;
  localparam int LIB_LAT = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flash_in;
  logic [11:0] prog_len_in;
  logic [11:0] lib_addr_out;
  logic [7:0]  lib_data_in;
  logic        busy_out;
  logic [1:0]  req_in, we_in;
  logic [23:0] addr_in;
  logic [15:0] data_in;
  logic [1:0]  gnt_out, rvalid_out;
  logic [7:0]  rdata_out;

  chip8_mem_arbiter dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .flash_in     (flash_in),
    .prog_len_in  (prog_len_in),
    .lib_addr_out (lib_addr_out),
    .lib_data_in  (lib_data_in),
    .busy_out     (busy_out),
    .req_in       (req_in),
    .we_in        (we_in),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .gnt_out      (gnt_out),
    .rvalid_out   (rvalid_out),
    .rdata_out    (rdata_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         port;
    logic [7:0] data;
    bit         known;
    int         due;
  } rd_t;

  rd_t        sb[$];
  logic [7:0] mdl_mem [4096];
  bit         known [4096];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         rr_last = NP - 1;
  int         busy_rem = 0;
  int         ld_idx = 0;
  int         ld_len = 0;
  bit         mon_en = 1'b0;

  // Library model: byte i = seed + i, delivered LIB_LAT cycles after its address.
  logic [7:0]  lib_seed = 8'h00;
  logic [11:0] lib_sh0 = '0, lib_sh1 = '0;
  always @(posedge clk_in) begin
    lib_sh0 <= lib_addr_out;
    lib_sh1 <= lib_sh0;
  end
  assign lib_data_in = lib_seed + lib_sh1[7:0];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding read, on the cycle it is due.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (rvalid_out != 2'b00) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", 32'(rvalid_out), 32'd0);
        end else begin
          rd_t e;
          e = sb.pop_front();
          chk("rvalid_port", 32'(rvalid_out), 32'd1 << e.port);
          chk("rvalid_cycle", cyc, e.due);
          if (e.known) chk("rdata", 32'(rdata_out), 32'(e.data));
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("rvalid_missing", 32'(rvalid_out), 32'd1 << sb[0].port);
        void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus: entered just after a posedge, returns just after the next one.
  task automatic tick();
    logic [1:0] eg;
    int         k;
    eg = 2'b00;
    k  = -1;
    @(negedge clk_in);
    if (flash_in) begin
      chk("busy_at_flash", 32'(busy_out), 32'd0);
    end else if (busy_rem > 0) begin
      chk("busy_high", 32'(busy_out), 32'd1);
      if (ld_idx < ld_len) begin
        chk("lib_addr", 32'(lib_addr_out), ld_idx);
        ld_idx++;
      end
      busy_rem--;
    end else begin
      chk("busy_low", 32'(busy_out), 32'd0);
      for (int off = 1; off <= NP; off++) begin
        int p = (rr_last + off) % NP;
        if (k < 0 && req_in[p]) k = p;
      end
    end
    if (k >= 0) eg = 2'(1 << k);
    chk("gnt", 32'(gnt_out), 32'(eg));
    if (k >= 0) begin
      logic [11:0] a;
      a = addr_in[k*12 +: 12];
      rr_last = k;
      if (we_in[k]) begin
        mdl_mem[a] = data_in[k*8 +: 8];
        known[a]   = 1'b1;
      end else begin
        sb.push_back('{port: k, data: mdl_mem[a], known: known[a], due: cyc + RAM_LAT});
      end
    end
    if (flash_in) begin
      busy_rem = (prog_len_in == 0) ? 1 : int'(prog_len_in) + LIB_LAT;
      ld_idx   = 0;
      ld_len   = int'(prog_len_in);
    end
    @(posedge clk_in);
    #1;
    if (k >= 0) req_in[k] = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    chk("rst_gnt", 32'(gnt_out), 32'd0);
    chk("rst_rvalid", 32'(rvalid_out), 32'd0);
    chk("rst_rdata", 32'(rdata_out), 32'd0);
    chk("rst_lib_addr", 32'(lib_addr_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    sb.delete();
    busy_rem = 0;
    rr_last  = NP - 1;
    mon_en   = 1'b1;
  endtask

  task automatic set_req(input int p, input bit we, input logic [11:0] a, input logic [7:0] d);
    req_in[p]         = 1'b1;
    we_in[p]          = we;
    addr_in[p*12 +: 12] = a;
    data_in[p*8 +: 8]   = d;
  endtask

  task automatic do_access(input int p, input bit we, input logic [11:0] a, input logic [7:0] d);
    set_req(p, we, a, d);
    for (int n = 0; n < 20 && req_in[p]; n++) tick();
    if (req_in[p]) begin
      chk("grant_timeout", 32'(req_in[p]), 32'd0);
      req_in[p] = 1'b0;
    end
  endtask

  // Start a copy; the model takes the first nwr bytes as written. abort resets after nwr writes.
  task automatic flash(input int len, input logic [7:0] seed, input int nwr, input bit abort);
    lib_seed    = seed;
    prog_len_in = 12'(len);
    flash_in    = 1'b1;
    for (int i = 0; i < nwr; i++) begin
      mdl_mem[12'(32'h200 + i)] = 8'(seed + 8'(i));
      known[12'(32'h200 + i)]   = 1'b1;
    end
    tick();
    flash_in = 1'b0;
    if (abort) begin
      repeat (nwr + LIB_LAT) tick();
      do_reset();
    end else begin
      for (int n = 0; n < len + 20 && busy_rem > 0; n++) tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int l;
    rst_in      = 1'b0;
    flash_in    = 1'b0;
    prog_len_in = '0;
    req_in      = '0;
    we_in       = '0;
    addr_in     = '0;
    data_in     = '0;
    repeat (2) @(posedge clk_in);
    #1;
    do_reset();

    // Write then read back through the other port.
    do_access(1, 1'b1, 12'h300, 8'hAB);
    do_access(0, 1'b0, 12'h300, 8'h00);
    repeat (4) tick();

    // Both ports hammering reads: grants must alternate starting at port 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b0, 12'h300, 8'h00);
      set_req(1, 1'b0, 12'h301, 8'h00);
      tick();
    end
    req_in = '0;
    repeat (4) tick();

    // Four-byte copy with a request parked during busy.
    set_req(1, 1'b0, 12'h202, 8'h00);
    flash(4, 8'h10, 4, 1'b0);
    for (int a = 0; a < 4; a++) do_access(0, 1'b0, 12'(32'h200 + a), 8'h00);
    repeat (4) tick();

    // Zero-length copy: one busy cycle, pending read served right after.
    set_req(0, 1'b0, 12'h200, 8'h00);
    flash(0, 8'h77, 0, 1'b0);
    tick();
    repeat (4) tick();

    // Prefill 0x200-0x207, then abort a second copy after three bytes.
    flash(8, 8'h60, 8, 1'b0);
    flash(8, 8'h40, 3, 1'b1);
    for (int a = 0; a < 8; a++) do_access(a % 2, 1'b0, 12'(32'h200 + a), 8'h00);
    repeat (4) tick();

    // Random traffic with occasional copies.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req_in[p] && $urandom_range(0, 1) == 1) begin
          set_req(p, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 1 ? 12'h200 : 12'h3F0) + 12'($urandom_range(0, 15)),
                  8'($urandom));
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        l = int'($urandom_range(0, 12));
        flash(l, 8'($urandom), l, 1'b0);
      end else begin
        tick();
      end
    end
    req_in = '0;
    repeat (6) tick();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
